// File: rtl/apb_spi_pkg.sv
// Shared APB/SPI definitions: bus widths, APB requester state encoding
// and the SPI core register map.
package apb_spi_pkg;

   localparam int APB_ADDR_WIDTH = 3;
   localparam int APB_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   localparam logic [2:0] ADDR_CR1 = 3'b000;
   localparam logic [2:0] ADDR_CR2 = 3'b001;
   localparam logic [2:0] ADDR_BR  = 3'b010;
   localparam logic [2:0] ADDR_SR  = 3'b011;
   localparam logic [2:0] ADDR_DR  = 3'b101;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: clr restarts, en counts a stalled cycle.
// Ports: clk, rst (sync high), clr, en in; expired out (count at limit).
module apb_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit ARMED = (TIMEOUT_CYCLES != 0);

   logic [CW-1:0] count;

   // Saturating so a disabled timeout never wraps into a false hit.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && count != '1)
         count <= count + CW'(1);
   end

   assign expired = ARMED && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester for the SPI core register port: one command per
// valid/ready handshake, IDLE/SETUP/ACCESS sequencing, timeout abort.
// Ports: cmd_* request in, rsp_* one-cycle response out, busy,
// APB P* bus signals; PCLK clock, PRESET sync active-high reset.
module apb_master #(
   parameter int APB_ADDR_WIDTH = apb_spi_pkg::APB_ADDR_WIDTH,
   parameter int APB_DATA_WIDTH = apb_spi_pkg::APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
   output logic                      rsp_valid,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      busy,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [APB_DATA_WIDTH-1:0] PWDATA,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   import apb_spi_pkg::*;

   apb_state_e state;
   apb_state_e next;

   logic accept;
   logic done;
   logic tmo;
   logic expired;

   assign done      = (state == ACCESS) && PREADY;
   assign tmo       = (state == ACCESS) && !PREADY && expired;
   assign cmd_ready = !PRESET && ((state == IDLE) || done);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);

   apb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (PCLK),
      .rst    (PRESET),
      .clr    (state == SETUP),
      .en     ((state == ACCESS) && !PREADY),
      .expired(expired)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next    = state;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept)
               next = SETUP;
         end
         SETUP: begin
            PSEL = 1'b1;
            next = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // Completion beats timeout when both land together.
            if (done)
               next = accept ? SETUP : IDLE;
            else if (tmo)
               next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
      end else if (accept) begin
         PADDR  <= cmd_addr;
         PWRITE <= cmd_write;
         PWDATA <= cmd_wdata;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid   <= done || tmo;
         rsp_rdata   <= (done && !PWRITE) ? PRDATA : '0;
         rsp_err     <= (done && PSLVERR) || tmo;
         rsp_timeout <= tmo;
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master against a small APB slave model
// with programmable wait states, error injection and a stuck mode.
module tb_apb_master;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [2:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic       busy;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [2:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   apb_master #(
      .APB_ADDR_WIDTH(3),
      .APB_DATA_WIDTH(8),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .busy       (busy),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   // Slave model
   logic [7:0] mem [8];
   int         wait_n = 1;
   int         acc_cnt = 0;
   bit         stuck = 0;
   bit         err_mode = 0;
   bit         err_early = 0;

   assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);
   assign PRDATA  = mem[PADDR];
   assign PSLVERR = (err_mode && PREADY) ||
                    (err_early && PSEL && PENABLE && !PREADY);

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE)
         mem[PADDR] <= PWDATA;
   end

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       to;
      int         acc;
      int         lat;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   // Response monitor / scoreboard pop
   always @(negedge PCLK) begin
      if (!PRESET) begin
         if (rsp_valid) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
               chk("rsp_latency", cyc - e.acc, e.lat);
            end
         end else begin
            chk("rsp_idle_zero",
                {22'd0, rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
         end
      end
   end

   task automatic issue(input logic w, input logic [2:0] a,
                        input logic [7:0] d, input logic [7:0] xr,
                        input logic xe, input logic xt,
                        input int lat, input bit push);
      int n;
      n = 0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
      if (push)
         q.push_back('{xr, xe, xt, cyc, lat});
   endtask

   task automatic drop_cmd();
      @(negedge PCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(negedge PCLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_en;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[1] = 8'h12;
      mem[2] = 8'h37;
      mem[3] = 8'h81;
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 3'd0;
      cmd_wdata = 8'd0;

      // Reset state
      repeat (3) @(negedge PCLK);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_psel", {31'd0, PSEL}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // Write CR1, PREADY on second ACCESS cycle
      wait_n = 1;
      issue(1'b1, 3'd0, 8'h54, 8'h00, 1'b0, 1'b0, 4, 1'b1);
      drop_cmd();
      chk("wr_c1_psel", {31'd0, PSEL}, 32'd1);
      chk("wr_c1_pen", {31'd0, PENABLE}, 32'd0);
      chk("wr_c1_pwdata", {24'd0, PWDATA}, 32'h54);
      chk("wr_c1_pwrite", {31'd0, PWRITE}, 32'd1);
      @(negedge PCLK);
      chk("wr_c2_pen", {30'd0, PSEL, PENABLE}, 32'd3);
      @(negedge PCLK);
      chk("wr_c3_pen", {30'd0, PSEL, PENABLE}, 32'd3);
      @(negedge PCLK);
      chk("wr_c4_idle", {30'd0, PSEL, PENABLE}, 32'd0);
      settle();

      // Read BR with zero wait
      wait_n = 0;
      issue(1'b0, 3'd2, 8'h00, 8'h37, 1'b0, 1'b0, 3, 1'b1);
      drop_cmd();
      settle();

      // Back-to-back: write DR then read SR, cmd_valid held
      wait_n = 1;
      issue(1'b1, 3'd5, 8'hA5, 8'h00, 1'b0, 1'b0, 4, 1'b1);
      issue(1'b0, 3'd3, 8'h00, 8'h81, 1'b0, 1'b0, 4, 1'b1);
      chk("b2b_old_paddr", {29'd0, PADDR}, 32'd5);
      drop_cmd();
      chk("b2b_new_paddr", {29'd0, PADDR}, 32'd3);
      chk("b2b_setup", {30'd0, PSEL, PENABLE}, 32'd2);
      chk("b2b_old_rsp", {31'd0, rsp_valid}, 32'd1);
      settle();

      // Read back what the slave stored
      issue(1'b0, 3'd0, 8'h00, 8'h54, 1'b0, 1'b0, 4, 1'b1);
      drop_cmd();
      settle();

      // PSLVERR at completion, read and write
      err_mode = 1;
      issue(1'b0, 3'd5, 8'h00, 8'hA5, 1'b1, 1'b0, 4, 1'b1);
      drop_cmd();
      settle();
      issue(1'b1, 3'd1, 8'h66, 8'h00, 1'b1, 1'b0, 4, 1'b1);
      drop_cmd();
      settle();
      err_mode = 0;

      // PSLVERR only during wait states is ignored
      err_early = 1;
      wait_n = 2;
      issue(1'b0, 3'd2, 8'h00, 8'h37, 1'b0, 1'b0, 5, 1'b1);
      drop_cmd();
      settle();
      err_early = 0;

      // Timeout with PREADY stuck low
      stuck = 1;
      issue(1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b1, 6, 1'b1);
      drop_cmd();
      n_en = 0;
      for (int i = 0; i < 20; i++) begin
         if (PENABLE) n_en++;
         if (!PSEL) break;
         @(negedge PCLK);
      end
      chk("to_access_cycles", n_en, 32'd4);
      chk("to_psel", {31'd0, PSEL}, 32'd0);
      chk("to_busy", {31'd0, busy}, 32'd0);
      stuck = 0;
      settle();

      // Normal transfer after timeout
      wait_n = 1;
      issue(1'b0, 3'd1, 8'h00, 8'h66, 1'b0, 1'b0, 4, 1'b1);
      drop_cmd();
      settle();

      // Reset in ACCESS drops the transfer
      wait_n = 3;
      issue(1'b1, 3'd1, 8'h99, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      drop_cmd();
      @(negedge PCLK);
      @(negedge PCLK);
      chk("mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("mid_rst_bus", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("mid_rst_paddr", {29'd0, PADDR}, 32'd0);
      chk("mid_rst_pwdata", {24'd0, PWDATA}, 32'd0);
      chk("mid_rst_pwrite", {31'd0, PWRITE}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("after_rst_ready", {31'd0, cmd_ready}, 32'd1);
      wait_n = 1;
      issue(1'b0, 3'd3, 8'h00, 8'h81, 1'b0, 1'b0, 4, 1'b1);
      drop_cmd();
      settle();

      chk("queue_empty", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the SPI core's APB slave port: CR1, CR2, BR, SR and DR accesses.
- Accepts single register commands from a local controller (CPU-side bridge or test sequencer) over a valid/ready handshake.
- Runs the APB IDLE/SETUP/ACCESS sequence and waits on PREADY.
- Returns read data, PSLVERR and a timeout flag as a one-cycle response pulse.

Parameters:
- APB_ADDR_WIDTH, 3, PADDR/cmd_addr width.
- APB_DATA_WIDTH, 8, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  APB_ADDR_WIDTH  register address.
- cmd_wdata  in  APB_DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  APB_DATA_WIDTH  APB write data.
- PRDATA  in  APB_DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error; SPI slave asserts it while tip=1.

Behaviour:
- Clock and reset: single clock PCLK; reset is synchronous and active-high on PRESET.
- Reset values: every registered output is 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*), state=IDLE, wait counter=0.
  - busy=0 and cmd_ready=1 once reset is released.
  - While PRESET=1 all registers hold reset values and cmd_ready=0.
- States and transitions:
  - IDLE: PSEL=0, PENABLE=0. On accept go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0 and not timed out.
  - On PREADY=1:
    - if a command is accepted in the same cycle, go to SETUP;
    - otherwise go to IDLE.
- Command capture:
  - cmd_ready = (state==IDLE) || (state==ACCESS && PREADY).
  - On accept, register cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA.
  - These hold stable through SETUP and ACCESS, and keep their last values after completion.
- Latency:
  - Accept on edge 0 gives SETUP visible at cycle 1 and ACCESS at cycle 2.
  - PREADY high in ACCESS cycle n gives rsp_valid=1 in cycle n+1 for exactly one cycle.
  - Against the SPI slave, PREADY arrives in the second ACCESS cycle: 4 cycles from accept to rsp_valid.
- Response:
  - rsp_rdata = PRDATA when !PWRITE, else 0.
  - rsp_err = PSLVERR. rsp_timeout = 0.
  - rsp_* return to 0 when rsp_valid is low.
- Timeout:
  - The wait counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When counter == TIMEOUT_CYCLES-1 and PREADY=0, drop PSEL/PENABLE and go to IDLE.
  - The response pulse then carries rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the timeout cycle: normal completion wins.
  - The counter saturates and never wraps.
- Back-to-back transfers: completion plus new accept gives PSEL held at 1, PENABLE 1→0 (new SETUP), and the response for the old transfer in the same cycle as the new SETUP.
- Reset mid-transfer: the transfer is dropped with no response pulse, and the bus is idle on the next cycle.
- PSLVERR with PREADY=0 is ignored; it is sampled only at completion.

Decomposition:
- Shared package apb_spi_pkg holds:
  - APB_ADDR_WIDTH and APB_DATA_WIDTH.
  - APB state encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - SPI register addresses: CR1=3'b000, CR2=3'b001, BR=3'b010, SR=3'b011, DR=3'b101.
- One sub-module, apb_wait_timer: the wait counter with clear/enable/expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write CR1: cmd write addr=0 wdata=8'h54, slave PREADY in second ACCESS cycle → PSEL 1 for 3 cycles, PENABLE 1 for 2, PWDATA=8'h54, rsp_valid 4 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read BR with zero wait: PREADY tied 1, PRDATA=8'h37 → rsp_valid 3 cycles after accept, rsp_rdata=8'h37.
- Back-to-back write DR 8'hA5 then read SR with cmd_valid held → no IDLE cycle between transfers, PADDR 5→3 at the second SETUP, two rsp_valid pulses.
- PSLVERR: PSLVERR=1 with PREADY → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 → ACCESS lasts 4 cycles, then PSEL=0 and rsp_err=rsp_timeout=1.
- Reset in ACCESS: PRESET=1 for one cycle → all outputs 0 next cycle, no rsp_valid, next command completes normally.
